ising_run_ctrl: RTL and testbench

//  Run sequencer for the coupled-oscillator spin array. Accepts a run command, holds

---
 rtl/ising_run_ctrl_pkg.sv | 22 ++
 rtl/ising_run_ctrl_phase_sync.sv | 30 +++
 rtl/ising_run_ctrl.sv | 169 ++++++++++++++++
 tb/tb_ising_run_ctrl.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/ising_run_ctrl_pkg.sv
// Shared types for the spin-array run sequencer: FSM state encoding and state decode helpers.
package ising_run_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RESET = 3'd1,
    ST_RUN   = 3'd2,
    ST_SYNC  = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  // The array is considered owned by the sequencer in these states; weight writes are blocked.
  function automatic logic is_busy(input state_t s);
    return (s == ST_RESET) || (s == ST_RUN) || (s == ST_SYNC);
  endfunction

  // Oscillators are released (ising_rstn high) only while running or flushing the synchronizer.
  function automatic logic is_released(input state_t s);
    return (s == ST_RUN) || (s == ST_SYNC);
  endfunction

endpackage

// File: rtl/ising_run_ctrl_phase_sync.sv
// Multi-stage synchronizer bringing the free-running spin phases into the clk domain.
module phase_sync #(
  parameter int N      = 8,
  parameter int STAGES = 2
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic [N-1:0] i_async,
  output logic [N-1:0] o_sync
);

  logic [N-1:0] r_stage [STAGES];

  // Shift chain; stage 0 is the only flop that sees the asynchronous input.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < STAGES; i++) begin
        r_stage[i] <= {N{1'b0}};
      end
    end else begin
      r_stage[0] <= i_async;
      for (int i = 1; i < STAGES; i++) begin
        r_stage[i] <= r_stage[i-1];
      end
    end
  end

  assign o_sync = r_stage[STAGES-1];

endmodule

// File: rtl/ising_run_ctrl.sv
// Run sequencer for the coupled-oscillator spin array: reset hold, timed release,
// synchronized phase capture, and AXI weight-write gating while the array oscillates.
module ising_run_ctrl
  import ising_run_ctrl_pkg::*;
#(
  parameter int N           = 8,
  parameter int RST_CYCLES  = 16,
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             axi_rstn,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [CNT_W-1:0] run_cycles,
  input  logic             abort,
  input  logic             wready_in,
  output logic             wready_out,
  output logic             ising_rstn,
  input  logic [N-1:0]     phase_in,
  output logic [N-1:0]     phase_out,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] run_count
);

  localparam logic [CNT_W-1:0] ZERO      = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] ONE       = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] RST_LOAD  = CNT_W'(RST_CYCLES);
  localparam logic [CNT_W-1:0] SYNC_LOAD = CNT_W'(SYNC_STAGES - 1);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : (v + ONE);
  endfunction

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_len;
  logic [CNT_W-1:0] r_run_count;
  logic [N-1:0]     r_phase_out;
  logic [N-1:0]     w_phase_sync;
  logic             r_start_ready;
  logic             r_busy;
  logic             r_done;
  logic             r_ising_rstn;
  logic             w_accept;
  logic             w_cnt_zero;
  logic             w_rstn_nxt;
  logic             w_busy_nxt;
  logic             w_done_nxt;
  logic             w_ready_nxt;

  phase_sync #(
    .N      (N),
    .STAGES (SYNC_STAGES)
  ) u_phase_sync (
    .clk     (clk),
    .rstn    (axi_rstn),
    .i_async (phase_in),
    .o_sync  (w_phase_sync)
  );

  assign w_accept   = start_valid & r_start_ready;
  assign w_cnt_zero = (r_cnt == ZERO);

  // State register.
  always_ff @(posedge clk or negedge axi_rstn) begin
    if (!axi_rstn) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic; a start in IDLE/DONE takes precedence over any abort.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE, ST_DONE: begin
        if (w_accept) w_state_nxt = ST_RESET;
        else          w_state_nxt = r_state;
      end
      ST_RESET: begin
        if (abort)           w_state_nxt = ST_IDLE;
        else if (w_cnt_zero) w_state_nxt = ST_RUN;
        else                 w_state_nxt = ST_RESET;
      end
      ST_RUN: begin
        if (abort)           w_state_nxt = ST_IDLE;
        else if (w_cnt_zero) w_state_nxt = ST_SYNC;
        else                 w_state_nxt = ST_RUN;
      end
      ST_SYNC: begin
        if (abort)           w_state_nxt = ST_IDLE;
        else if (w_cnt_zero) w_state_nxt = ST_DONE;
        else                 w_state_nxt = ST_SYNC;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Output decode from the next state so the registered outputs line up with the state.
  always_comb begin
    w_rstn_nxt  = is_released(w_state_nxt);
    w_busy_nxt  = is_busy(w_state_nxt);
    w_done_nxt  = (w_state_nxt == ST_DONE);
    w_ready_nxt = ~w_busy_nxt;
  end

  // Registered status outputs.
  always_ff @(posedge clk or negedge axi_rstn) begin
    if (!axi_rstn) begin
      r_ising_rstn  <= 1'b0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_start_ready <= 1'b1;
    end else begin
      r_ising_rstn  <= w_rstn_nxt;
      r_busy        <= w_busy_nxt;
      r_done        <= w_done_nxt;
      r_start_ready <= w_ready_nxt;
    end
  end

  // Phase down-counter, latched run length, elapsed-run counter and result capture.
  // r_cnt is loaded with (phase length - 1) on entering RUN/SYNC, but with the full
  // RST_CYCLES on accept, which gives the extra accept cycle of reset hold.
  always_ff @(posedge clk or negedge axi_rstn) begin
    if (!axi_rstn) begin
      r_cnt       <= ZERO;
      r_len       <= ONE;
      r_run_count <= ZERO;
      r_phase_out <= {N{1'b0}};
    end else if (w_accept) begin
      r_len       <= (run_cycles == ZERO) ? ONE : run_cycles;
      r_cnt       <= RST_LOAD;
      r_run_count <= ZERO;
    end else if (abort) begin
      r_cnt <= r_cnt;
    end else begin
      case (r_state)
        ST_RESET: begin
          if (w_cnt_zero) r_cnt <= r_len - ONE;
          else            r_cnt <= r_cnt - ONE;
        end
        ST_RUN: begin
          r_run_count <= sat_inc(r_run_count);
          if (w_cnt_zero) r_cnt <= SYNC_LOAD;
          else            r_cnt <= r_cnt - ONE;
        end
        ST_SYNC: begin
          if (w_cnt_zero) r_phase_out <= w_phase_sync;
          else            r_cnt       <= r_cnt - ONE;
        end
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  assign start_ready = r_start_ready;
  assign busy        = r_busy;
  assign done        = r_done;
  assign ising_rstn  = r_ising_rstn;
  assign phase_out   = r_phase_out;
  assign run_count   = r_run_count;
  assign wready_out  = wready_in & ~r_busy;

endmodule

// File: tb/tb_ising_run_ctrl.sv
// Directed bench for ising_run_ctrl with a scoreboard of expected run results.
module tb_ising_run_ctrl;

  localparam int N   = 8;
  localparam int RST = 16;
  localparam int SS  = 2;
  localparam int CW  = 32;

  logic          clk;
  logic          axi_rstn;
  logic          start_valid;
  logic          start_ready;
  logic [CW-1:0] run_cycles;
  logic          abort;
  logic          wready_in;
  logic          wready_out;
  logic          ising_rstn;
  logic [N-1:0]  phase_in;
  logic [N-1:0]  phase_out;
  logic          busy;
  logic          done;
  logic [CW-1:0] run_count;

  ising_run_ctrl #(.N(N), .RST_CYCLES(RST), .SYNC_STAGES(SS), .CNT_W(CW)) dut (
    .clk         (clk),
    .axi_rstn    (axi_rstn),
    .start_valid (start_valid),
    .start_ready (start_ready),
    .run_cycles  (run_cycles),
    .abort       (abort),
    .wready_in   (wready_in),
    .wready_out  (wready_out),
    .ising_rstn  (ising_rstn),
    .phase_in    (phase_in),
    .phase_out   (phase_out),
    .busy        (busy),
    .done        (done),
    .run_count   (run_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk  = 0;
  int n_pass = 0;
  int n_fail = 0;

  typedef struct {
    int          len_eff;
    logic [7:0]  phase;
    int          fall;
  } exp_t;
  exp_t sb[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic start_run(input logic [31:0] len, input logic [7:0] ph, input bit hold,
                           output int t0);
    exp_t e;
    @(negedge clk);
    phase_in    = ph;
    run_cycles  = len;
    start_valid = 1'b1;
    check("start_ready_before_accept", 32'(start_ready), 32'd1);
    @(posedge clk); #1;
    t0 = cyc;
    if (!hold) start_valid = 1'b0;
    e.len_eff = (len == 32'd0) ? 1 : int'(len);
    e.phase   = ph;
    e.fall    = t0 + RST + e.len_eff + SS + 1;
    sb.push_back(e);
  endtask

  task automatic wait_rise(input int t0, input string tag);
    int k;
    k = 0;
    while (!ising_rstn && k < 200) begin
      @(posedge clk); #1;
      k++;
    end
    check(tag, 32'(cyc), 32'(t0 + RST + 1));
  endtask

  task automatic finish_run(input string tag);
    exp_t e;
    int   k;
    k = 0;
    while (!done && k < 400) begin
      @(posedge clk); #1;
      k++;
    end
    check({tag, "_done"}, 32'(done), 32'd1);
    e = sb.pop_front();
    check({tag, "_done_cycle"}, 32'(cyc), 32'(e.fall));
    check({tag, "_phase_out"}, 32'(phase_out), 32'(e.phase));
    check({tag, "_run_count"}, run_count, 32'(e.len_eff));
    check({tag, "_rstn_low"}, 32'(ising_rstn), 32'd0);
    check({tag, "_busy_low"}, 32'(busy), 32'd0);
    check({tag, "_ready_high"}, 32'(start_ready), 32'd1);
  endtask

  initial begin
    int   t0;
    exp_t e;
    axi_rstn    = 1'b0;
    start_valid = 1'b0;
    run_cycles  = 32'd0;
    abort       = 1'b0;
    wready_in   = 1'b1;
    phase_in    = 8'h00;

    repeat (3) @(posedge clk);
    #1;
    check("rst_ising_rstn", 32'(ising_rstn), 32'd0);
    check("rst_start_ready", 32'(start_ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_phase_out", 32'(phase_out), 32'd0);
    check("rst_run_count", run_count, 32'd0);
    check("rst_wready_pass", 32'(wready_out), 32'd1);
    @(negedge clk);
    axi_rstn = 1'b1;

    // Basic run with write gating observed through the run.
    start_run(32'd100, 8'hA5, 1'b0, t0);
    check("basic_busy", 32'(busy), 32'd1);
    check("basic_ready_low", 32'(start_ready), 32'd0);
    check("basic_wready_reset", 32'(wready_out), 32'd0);
    check("basic_rstn_held", 32'(ising_rstn), 32'd0);
    wait_rise(t0, "basic_rise_cycle");
    repeat (50) @(posedge clk);
    #1;
    check("basic_wready_run", 32'(wready_out), 32'd0);
    check("basic_run_count_mid", run_count, 32'd50);
    finish_run("basic");
    check("basic_wready_done", 32'(wready_out), 32'd1);

    // Abort during RUN: phase_out keeps the previous result.
    start_run(32'd100, 8'h3C, 1'b0, t0);
    wait_rise(t0, "abort_rise_cycle");
    repeat (39) @(posedge clk);
    @(negedge clk);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_rstn", 32'(ising_rstn), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_phase_held", 32'(phase_out), 32'hA5);
    check("abort_ready", 32'(start_ready), 32'd1);
    void'(sb.pop_back());
    @(negedge clk);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    check("abort_idle_ignored", 32'(busy), 32'd0);

    // Zero-length run behaves as length one.
    start_run(32'd0, 8'h5A, 1'b0, t0);
    wait_rise(t0, "zero_rise_cycle");
    finish_run("zero");

    // Back-to-back with start_valid held high throughout.
    start_run(32'd3, 8'hC3, 1'b1, t0);
    wait_rise(t0, "b2b1_rise_cycle");
    finish_run("b2b1");
    @(posedge clk); #1;
    t0 = cyc;
    start_valid = 1'b0;
    check("b2b_done_cleared", 32'(done), 32'd0);
    check("b2b_busy", 32'(busy), 32'd1);
    e.len_eff = 3;
    e.phase   = 8'hC3;
    e.fall    = t0 + RST + 3 + SS + 1;
    sb.push_back(e);
    wait_rise(t0, "b2b2_rise_cycle");
    finish_run("b2b2");

    // Start and abort together in DONE: start wins.
    @(negedge clk);
    start_valid = 1'b1;
    abort       = 1'b1;
    run_cycles  = 32'd5;
    phase_in    = 8'h81;
    @(posedge clk); #1;
    t0 = cyc;
    start_valid = 1'b0;
    abort       = 1'b0;
    check("startabort_busy", 32'(busy), 32'd1);
    check("startabort_done", 32'(done), 32'd0);
    e.len_eff = 5;
    e.phase   = 8'h81;
    e.fall    = t0 + RST + 5 + SS + 1;
    sb.push_back(e);
    finish_run("startabort");

    // Asynchronous reset while in SYNC.
    start_run(32'd2, 8'h96, 1'b0, t0);
    wait_rise(t0, "arst_rise_cycle");
    repeat (2) @(posedge clk);
    #1;
    check("arst_pre_rstn", 32'(ising_rstn), 32'd1);
    @(negedge clk);
    axi_rstn = 1'b0;
    #1;
    check("arst_rstn", 32'(ising_rstn), 32'd0);
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_done", 32'(done), 32'd0);
    check("arst_ready", 32'(start_ready), 32'd1);
    check("arst_phase_out", 32'(phase_out), 32'd0);
    check("arst_run_count", run_count, 32'd0);
    void'(sb.pop_back());
    @(negedge clk);
    axi_rstn = 1'b1;
    repeat (2) @(posedge clk);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
